// File: rtl/alu_pkg.sv
// Shared op-code and state definitions for the sequential ALU and its
// iterative multiply/divide datapath.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MUL  = 4'd10,
        OP_DIVU = 4'd11,
        OP_REMU = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider. Operands are
// captured on start; done pulses during the last of WIDTH iteration cycles.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    // acc_q: product accumulator (MUL) or partial remainder (DIVU/REMU).
    // x_q:   shifted multiplicand (MUL) or dividend/quotient shifter (DIV).
    // y_q:   multiplier shifter (MUL) or divisor (DIV).
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       op_q;
    logic             dbz_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   diff_s;

    // One iteration step of the selected algorithm.
    always_comb begin
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        rem_sh_s = {acc_q, x_q[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, y_q};
        if (op_q == OP_MUL) begin
            acc_d = acc_q + (y_q[0] ? x_q : {WIDTH{1'b0}});
            x_d   = {x_q[WIDTH-2:0], 1'b0};
            y_d   = {1'b0, y_q[WIDTH-1:1]};
        end else if (!diff_s[WIDTH]) begin
            // A non-negative difference is below the divisor, so it fits WIDTH bits.
            acc_d = diff_s[WIDTH-1:0];
            x_d   = {x_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = rem_sh_s[WIDTH-1:0];
            x_d   = {x_q[WIDTH-2:0], 1'b0};
        end
    end

    // Final result is taken from the last step's next-state value.
    always_comb begin
        case (op_q)
            OP_MUL:  result = acc_d;
            OP_DIVU: result = x_d;
            default: result = acc_d;
        endcase
    end

    assign done        = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign div_by_zero = dbz_q;

    // Operand capture and iteration sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
            op_q   <= 4'd0;
            dbz_q  <= 1'b0;
            acc_q  <= {WIDTH{1'b0}};
            x_q    <= {WIDTH{1'b0}};
            y_q    <= {WIDTH{1'b0}};
        end else if (flush) begin
            busy_q <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= {CNT_W{1'b0}};
            op_q   <= op;
            dbz_q  <= (op != OP_MUL) && (b == {WIDTH{1'b0}});
            acc_q  <= {WIDTH{1'b0}};
            x_q    <= a;
            y_q    <= b;
        end else if (busy_q) begin
            acc_q <= acc_d;
            x_q   <= x_d;
            y_q   <= y_d;
            if (done) begin
                busy_q <= 1'b0;
                cnt_q  <= {CNT_W{1'b0}};
            end else begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops finish in one cycle, MUL/DIVU/REMU run
// through the iterative datapath. Results are held until consumed.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div_by_zero
);

    localparam int SH_W = $clog2(WIDTH);

    alu_state_e       state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             dbz_q;
    logic             accept_s;
    logic             iter_s;
    logic [SH_W-1:0]  shamt_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             md_done_s;
    logic [WIDTH-1:0] md_res_s;
    logic             md_dbz_s;

    assign in_ready    = (state_q == IDLE);
    assign accept_s    = in_valid && in_ready && !flush;
    assign iter_s      = is_iter_op(op);
    assign shamt_s     = b[SH_W-1:0];
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;

    // Single-cycle operations; undefined codes fall through to ADD.
    always_comb begin
        case (op)
            OP_SUB:  alu_res_s = a - b;
            OP_AND:  alu_res_s = a & b;
            OP_OR:   alu_res_s = a | b;
            OP_XOR:  alu_res_s = a ^ b;
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  alu_res_s = a << shamt_s;
            OP_SRL:  alu_res_s = a >> shamt_s;
            OP_SRA:  alu_res_s = $signed(a) >>> shamt_s;
            default: alu_res_s = a + b;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .start       (accept_s && iter_s),
        .op          (op),
        .a           (a),
        .b           (b),
        .done        (md_done_s),
        .result      (md_res_s),
        .div_by_zero (md_dbz_s)
    );

    // Control FSM with registered result and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            zero_q      <= 1'b1;
            dbz_q       <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s && iter_s) begin
                        state_q <= BUSY;
                    end else if (accept_s) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= alu_res_s;
                        zero_q      <= (alu_res_s == {WIDTH{1'b0}});
                        dbz_q       <= 1'b0;
                    end
                end
                BUSY: begin
                    if (md_done_s) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= md_res_s;
                        zero_q      <= (md_res_s == {WIDTH{1'b0}});
                        dbz_q       <= md_dbz_s;
                    end
                end
                DONE: begin
                    // Consuming a result never overlaps with a new accept.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    logic [3:0]  sc_op  [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd13, 4'd15};
    logic [31:0] sc_a   [12] = '{32'hFFFFFFFF, 32'h00000000, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hAAAA5555, 32'hFFFFFFFF,
                                 32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'h80000000, 32'h00000002, 32'h7FFFFFFF};
    logic [31:0] sc_b   [12] = '{32'h00000001, 32'h00000001, 32'hFF00FF00, 32'h0F0F0000, 32'hFFFF0000, 32'h00000000,
                                 32'h00000000, 32'h0000003F, 32'h00000024, 32'h00000024, 32'h00000003, 32'h00000001};
    logic [31:0] sc_exp [12] = '{32'h00000000, 32'hFFFFFFFF, 32'hF000F000, 32'hFFFFF0F0, 32'h55555555, 32'h00000001,
                                 32'h00000000, 32'h80000000, 32'h08000000, 32'hF8000000, 32'h00000005, 32'h80000000};

    logic [3:0]  md_op  [7] = '{4'd10, 4'd10, 4'd11, 4'd12, 4'd11, 4'd12, 4'd11};
    logic [31:0] md_a   [7] = '{32'h00010001, 32'hFFFFFFFF, 32'd100, 32'd100, 32'd5, 32'd5, 32'hFFFFFFFF};
    logic [31:0] md_b   [7] = '{32'h00010001, 32'hFFFFFFFF, 32'd7, 32'd7, 32'd0, 32'd0, 32'h00000010};
    logic [31:0] md_exp [7] = '{32'h00020001, 32'h00000001, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h0FFFFFFF};
    logic        md_dbz [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one request, let it be accepted at the next edge, then scramble inputs.
    task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0; op = 4'd15; a = 32'hDEADBEEF; b = 32'hDEADBEEF;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle(); cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=00000000", result); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got=%0b exp=1", zero); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%0b exp=0", div_by_zero); end
        rst_n = 1'b1;
        cycle();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_single_cycle();
        for (int i = 0; i < 12; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sc_ready[%0d] got=%0b exp=1", i, in_ready); end
            send(sc_op[i], sc_a[i], sc_b[i]);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sc_latency[%0d] out_valid got=%0b exp=1", i, out_valid); end
            checks++; if (result !== sc_exp[i]) begin errors++; $display("FAIL sc_result[%0d] op=%0d got=%h exp=%h", i, sc_op[i], result, sc_exp[i]); end
            checks++; if (zero !== (sc_exp[i] == 32'h0)) begin errors++; $display("FAIL sc_zero[%0d] got=%0b exp=%0b", i, zero, (sc_exp[i] == 32'h0)); end
            checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL sc_dbz[%0d] got=%0b exp=0", i, div_by_zero); end
            out_ready = 1'b1;
            cycle();
            out_ready = 1'b0;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sc_consume[%0d] out_valid got=%0b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_muldiv();
        int bad;
        for (int i = 0; i < 7; i++) begin
            send(md_op[i], md_a[i], md_b[i]);
            bad = 0;
            for (int k = 1; k <= 32; k++) begin
                if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
                cycle();
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL md_busy_window[%0d] bad_cycles got=%0d exp=0", i, bad); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL md_latency[%0d] out_valid got=%0b exp=1", i, out_valid); end
            checks++; if (result !== md_exp[i]) begin errors++; $display("FAIL md_result[%0d] op=%0d got=%h exp=%h", i, md_op[i], result, md_exp[i]); end
            checks++; if (div_by_zero !== md_dbz[i]) begin errors++; $display("FAIL md_dbz[%0d] got=%0b exp=%0b", i, div_by_zero, md_dbz[i]); end
            checks++; if (zero !== 1'b0) begin errors++; $display("FAIL md_zero[%0d] got=%0b exp=0", i, zero); end
            out_ready = 1'b1;
            cycle();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        send(4'd11, 32'd100, 32'd7);
        repeat (32) cycle();
        op = 4'd12; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (out_valid !== 1'b1 || result !== 32'd14 || in_ready !== 1'b0) bad++;
            cycle();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable bad_cycles got=%0d exp=0", bad); end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_consume out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle in_ready got=%0b exp=1", in_ready); end
        cycle();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept in_ready got=%0b exp=0", in_ready); end
        repeat (32) cycle();
        checks++; if (out_valid !== 1'b1 || result !== 32'd2) begin errors++; $display("FAIL b2b_second valid=%0b result=%h exp valid=1 result=00000002", out_valid, result); end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        int bad;
        send(4'd11, 32'd100, 32'd7);
        repeat (9) cycle();
        flush = 1'b1; in_valid = 1'b1; op = 4'd0; a = 32'd2; b = 32'd3; out_ready = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_busy ready=%0b valid=%0b exp ready=1 valid=0", in_ready, out_valid); end
        bad = 0;
        repeat (40) begin
            if (out_valid !== 1'b0) bad++;
            cycle();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL flush_no_result bad_cycles got=%0d exp=0", bad); end
        send(4'd0, 32'd2, 32'd3);
        checks++; if (out_valid !== 1'b1 || result !== 32'd5) begin errors++; $display("FAIL flush_next_add valid=%0b result=%h exp valid=1 result=00000005", out_valid, result); end
        flush = 1'b1; out_ready = 1'b1;
        cycle();
        flush = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_done valid=%0b ready=%0b exp valid=0 ready=1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid();
        int bad;
        send(4'd10, 32'h00010001, 32'h00010001);
        repeat (5) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        bad = 0;
        repeat (40) begin
            if (out_valid !== 1'b0) bad++;
            cycle();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_busy_no_result bad_cycles got=%0d exp=0", bad); end
        send(4'd0, 32'd9, 32'd9);
        checks++; if (out_valid !== 1'b1 || result !== 32'd18) begin errors++; $display("FAIL rst_pre_done valid=%0b result=%h exp valid=1 result=00000012", out_valid, result); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || result !== 32'h0) begin errors++; $display("FAIL rst_done_async valid=%0b result=%h exp valid=0 result=00000000", out_valid, result); end
        #2 rst_n = 1'b1;
        cycle();
        send(4'd0, 32'd2, 32'd3);
        checks++; if (out_valid !== 1'b1 || result !== 32'd5) begin errors++; $display("FAIL rst_next_add valid=%0b result=%h exp valid=1 result=00000005", out_valid, result); end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_muldiv();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits; SHALL be legal for 8..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1: iteration counter width.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous abort of any in-flight operation.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block accepts a request this cycle.
REQ-008 op  input  4  operation code.
REQ-009 a  input  WIDTH  operand 1.
REQ-010 b  input  WIDTH  operand 2 or immediate.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 result  output  WIDTH  registered result.
REQ-014 zero  output  1  high when result == 0.
REQ-015 div_by_zero  output  1  result came from DIVU/REMU with b == 0.

Function
REQ-016 Op codes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL (low WIDTH bits), 11 DIVU, 12 REMU; codes 13-15 SHALL execute as ADD.
REQ-017 Shifts SHALL use b[$clog2(WIDTH)-1:0] as amount; ADD/SUB/MUL SHALL wrap modulo 2^WIDTH; SLT/SLTU SHALL return 1 or 0, zero-extended.
REQ-018 FSM states SHALL be IDLE, BUSY, DONE; a request is accepted when in_valid && in_ready; in_ready SHALL equal (state == IDLE).
REQ-019 Ops 0-9 and 13-15: IDLE -> DONE on accept; out_valid SHALL assert the cycle after accept (latency 1).
REQ-020 Ops 10-12: IDLE -> BUSY on accept, exactly WIDTH iteration cycles in BUSY (one bit per cycle, shift-add multiply, restoring divide), then DONE; out_valid SHALL assert WIDTH+1 cycles after accept.
REQ-021 DIVU with b == 0 SHALL return all ones; REMU with b == 0 SHALL return a; both SHALL set div_by_zero; such ops still take the full WIDTH+1 latency.
REQ-022 In DONE, result, zero, div_by_zero SHALL stay stable while out_valid && !out_ready; DONE -> IDLE when out_ready.
REQ-023 Operands SHALL be captured on accept; input changes afterwards SHALL not affect the result.
REQ-024 flush SHALL force IDLE next cycle from any state, deassert out_valid, discard the in-flight result, and block acceptance in that cycle; flush wins over in_valid and out_ready.
REQ-025 No new request SHALL be accepted in the same cycle a result is consumed (no bypass; back-to-back throughput one op per 2 cycles minimum).
REQ-026 zero and div_by_zero SHALL be registered alongside result, not derived from live inputs.

Reset
REQ-027 While rst_n low: state IDLE, out_valid 0, result 0, div_by_zero 0, counter 0; zero therefore 1; in_ready 1 after release.
REQ-028 Reset mid-BUSY or mid-DONE SHALL drop the operation with no result delivered.

Structure
REQ-029 Op-code constants SHALL live in shared package alu_pkg, reused by decode and alu_control.
REQ-030 Iterative MUL/DIVU/REMU datapath SHALL be sub-module alu_muldiv_iter (start, op, a, b -> done, result), parametrised by WIDTH; single-cycle ops remain in alu_seq.

Verification
REQ-031 ADD a=0xFFFFFFFF b=1 -> out_valid 1 cycle after accept, result 0, zero 1.
REQ-032 SRA a=0x80000000 b=0x24 (amount 4) -> result 0xF8000000; SLT a=0xFFFFFFFF b=0 -> 1; SLTU same -> 0.
REQ-033 MUL a=0x00010001 b=0x00010001 -> result 0x00020001 exactly 33 cycles after accept; in_ready 0 for cycles 1-32.
REQ-034 DIVU a=100 b=7 -> 14; REMU -> 2; DIVU b=0 -> 0xFFFFFFFF, div_by_zero 1; REMU a=5 b=0 -> 5.
REQ-035 Result held 5 cycles with out_ready 0 -> result stable, in_ready 0; out_ready 1 -> IDLE next cycle.
REQ-036 flush at BUSY cycle 10 of DIVU, and rst_n low mid-BUSY -> no out_valid, next ADD 2+3 returns 5 with latency 1.
